// File: rtl/conv_stream_unit_pkg.sv
// Shared types and defaults for the streaming convolution engine.
// Imported by the MAC and the top level.
package conv_stream_unit_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_LEN      = 4;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic [DEF_WIDTH-1:0] data_t;
    typedef data_t [DEF_LEN-1:0] data_vector;
    typedef logic [2*DEF_WIDTH+$clog2(DEF_LEN)-1:0] result_t;

endpackage

// File: rtl/conv_stream_unit_mac.sv
// Single multiply-accumulate lane, signed or unsigned by parameter.
// nxt exposes acc plus the current product so the caller can capture the final sum.
module conv_mac
    import conv_stream_unit_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int RES_W  = 2*DEF_WIDTH + $clog2(DEF_LEN),
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [RES_W-1:0] acc,
    output logic [RES_W-1:0] nxt
);

    localparam int P_W = 2*WIDTH;
    localparam int E_W = RES_W - P_W;

    logic [P_W-1:0] ax;
    logic [P_W-1:0] bx;
    logic [P_W-1:0] prod;
    logic [RES_W-1:0] prod_x;

    // low 2*WIDTH bits of the extended-operand product are exact either way
    always_comb begin
        ax = SIGNED ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        bx = SIGNED ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod = ax * bx;
        prod_x = SIGNED ? {{E_W{prod[P_W-1]}}, prod} : {{E_W{1'b0}}, prod};
    end

    assign nxt = acc + prod_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= nxt;
        end
    end

endmodule

// File: rtl/conv_stream_unit.sv
// Multi-channel streaming 1-D convolution: per-channel sample windows,
// one MAC per cycle against a latched kernel, ready/valid result port.
module conv_stream_unit
    import conv_stream_unit_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LEN      = DEF_LEN,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter bit SIGNED   = 1'b0,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int RES_W   = 2*WIDTH + $clog2(LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [CH_W-1:0]      in_chan,
    input  logic                 in_clear,
    input  logic [LEN*WIDTH-1:0] kernel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [RES_W-1:0]     result,
    output logic [CH_W-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int T_W = $clog2(LEN);

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]     win [CHANNELS][LEN];
    logic [LEN*WIDTH-1:0] kern_q;
    logic [CH_W-1:0]      chan_q;
    logic [T_W-1:0]       tap;
    logic [CH_W-1:0]      chan_in;
    logic                 accept;
    logic                 last;
    logic                 mac_en;
    logic [RES_W-1:0]     acc;
    logic [RES_W-1:0]     acc_nxt;

    assign chan_in = CH_W'(32'(in_chan) % CHANNELS);
    assign accept  = in_valid && in_ready;
    assign last    = (tap == T_W'(LEN-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        mac_en    = (state == CALC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < LEN; k++) begin
                    win[c][k] <= '0;
                end
            end
            kern_q   <= '0;
            chan_q   <= '0;
            tap      <= '0;
            result   <= '0;
            out_chan <= '0;
        end else begin
            if (accept) begin
                chan_q <= chan_in;
                kern_q <= kernel;
                tap    <= '0;
                win[chan_in][0] <= in_data;
                for (int k = 1; k < LEN; k++) begin
                    win[chan_in][k] <= in_clear ? '0 : win[chan_in][k-1];
                end
            end
            if (mac_en) begin
                tap <= tap + 1'b1;
                // capture the sum including the last tap's product
                if (last) begin
                    result   <= acc_nxt;
                    out_chan <= chan_q;
                end
            end
        end
    end

    conv_mac #(
        .WIDTH  (WIDTH),
        .RES_W  (RES_W),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (mac_en),
        .a   (win[chan_q][tap]),
        .b   (kern_q[tap*WIDTH +: WIDTH]),
        .acc (acc),
        .nxt (acc_nxt)
    );

endmodule

// File: tb/tb_conv_stream_unit.sv
// Directed-vector bench for conv_stream_unit, unsigned and signed instances side by side.
module tb_conv_stream_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [63:0]  in_data = '0;
    logic [1:0]   in_chan = '0;
    logic         in_clear = 1'b0;
    logic [255:0] kernel = '0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid;
    logic [129:0] result;
    logic [1:0]   out_chan;
    logic         ir_s, ov_s;
    logic [129:0] res_s;
    logic [1:0]   oc_s;

    int cnt = 0;
    int errs = 0;

    logic [63:0] mw [4][4];

    always #5 clk = ~clk;

    conv_stream_unit #(.SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_chan(in_chan),
        .in_clear(in_clear), .kernel(kernel), .in_valid(in_valid),
        .in_ready(in_ready), .result(result), .out_chan(out_chan),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    conv_stream_unit #(.SIGNED(1'b1)) u_sdut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_chan(in_chan),
        .in_clear(in_clear), .kernel(kernel), .in_valid(in_valid),
        .in_ready(ir_s), .result(res_s), .out_chan(oc_s),
        .out_valid(ov_s), .out_ready(out_ready)
    );

    typedef struct {
        int           ch;
        logic         clr;
        logic [63:0]  d;
        logic [255:0] k;
        logic [129:0] eu;
        logic [129:0] es;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [129:0] act,
                       input logic [129:0] exp);
        cnt++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 4; t++)
                mw[c][t] = '0;
    endtask

    task automatic mdl_push(input int ch, input logic clr, input logic [63:0] d);
        for (int t = 3; t > 0; t--)
            mw[ch][t] = clr ? 64'd0 : mw[ch][t-1];
        mw[ch][0] = d;
    endtask

    function automatic logic [129:0] mdl(input int ch, input logic [255:0] k,
                                         input bit sg);
        logic [129:0] s, a, b;
        logic [63:0] kt;
        s = '0;
        for (int t = 0; t < 4; t++) begin
            kt = k[t*64 +: 64];
            a = sg ? {{66{mw[ch][t][63]}}, mw[ch][t]} : {66'd0, mw[ch][t]};
            b = sg ? {{66{kt[63]}}, kt} : {66'd0, kt};
            s = s + a * b;
        end
        return s;
    endfunction

    // one full transaction with out_ready high; latency counted including the accept edge
    task automatic txn(input int ch, input logic clr, input logic [63:0] d,
                       input logic [255:0] k, input logic [129:0] eu,
                       input logic [129:0] es, input bit use_mdl,
                       input string tag);
        int n;
        logic [129:0] xu, xs;
        @(negedge clk);
        in_chan = 2'(ch);
        in_clear = clr;
        in_data = d;
        kernel = k;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, 130'(in_ready), 130'd1);
        @(posedge clk);
        mdl_push(ch, clr, d);
        xu = use_mdl ? mdl(ch, k, 1'b0) : eu;
        xs = use_mdl ? mdl(ch, k, 1'b1) : es;
        @(negedge clk);
        in_valid = 1'b0;
        in_clear = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 130'(n), 130'd5);
        chk({tag, " result"}, result, xu);
        chk({tag, " out_chan"}, 130'(out_chan), 130'(ch));
        chk({tag, " signed ov"}, 130'(ov_s), 130'd1);
        chk({tag, " signed result"}, res_s, xs);
    endtask

    logic [255:0] kd, ko, kn, kr;
    logic [129:0] m2, un;
    logic [63:0]  mx;
    int n;

    initial begin
        kd = {64'd4, 64'd3, 64'd2, 64'd1};
        mx = 64'hFFFF_FFFF_FFFF_FFFF;
        ko = {4{mx}};
        kn = {192'd0, 64'hFFFF_FFFF_FFFF_FFFE};
        m2 = 130'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        un = 130'hFFFF_FFFF_FFFF_FFFD_0000_0000_0000_0002;

        tbl[0]  = '{0, 1'b0, 64'd3, kd, 130'd3,  130'd3};
        tbl[1]  = '{0, 1'b0, 64'd5, kd, 130'd11, 130'd11};
        tbl[2]  = '{1, 1'b0, 64'd7, kd, 130'd7,  130'd7};
        tbl[3]  = '{0, 1'b0, 64'd1, kd, 130'd20, 130'd20};
        tbl[4]  = '{0, 1'b1, 64'd2, kd, 130'd2,  130'd2};
        tbl[5]  = '{2, 1'b0, mx, ko, m2,             130'd1};
        tbl[6]  = '{2, 1'b0, mx, ko, m2 + m2,        130'd2};
        tbl[7]  = '{2, 1'b0, mx, ko, m2 + m2 + m2,   130'd3};
        tbl[8]  = '{2, 1'b0, mx, ko, m2 + m2 + m2 + m2, 130'd4};
        tbl[9]  = '{3, 1'b0, mx, kn, un,             130'd2};
        tbl[10] = '{1, 1'b0, 64'd1, kd, 130'd26, 130'd26};

        mdl_reset();
        repeat (3) @(negedge clk);
        chk("reset in_ready", 130'(in_ready), 130'd1);
        chk("reset out_valid", 130'(out_valid), 130'd0);
        chk("reset result", result, 130'd0);
        chk("reset out_chan", 130'(out_chan), 130'd0);
        rst = 1'b1;

        for (int i = 0; i < 4; i++)
            txn(tbl[i].ch, tbl[i].clr, tbl[i].d, tbl[i].k,
                tbl[i].eu, tbl[i].es, 1'b0, $sformatf("vec%0d", i));

        // stall in DONE with spurious in_valid; ch1 [2,7,0,0] -> 16
        @(negedge clk);
        out_ready = 1'b0;
        in_chan = 2'd1;
        in_data = 64'd2;
        kernel = kd;
        in_valid = 1'b1;
        @(posedge clk);
        mdl_push(1, 1'b0, 64'd2);
        @(negedge clk);
        in_data = 64'd99;
        n = 1;
        while (!out_valid && n < 20) begin
            chk("stall calc in_ready", 130'(in_ready), 130'd0);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("stall latency", 130'(n), 130'd5);
        for (int c = 0; c < 10; c++) begin
            chk("stall out_valid", 130'(out_valid), 130'd1);
            chk("stall result", result, 130'd16);
            chk("stall out_chan", 130'(out_chan), 130'd1);
            chk("stall in_ready", 130'(in_ready), 130'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post hs out_valid", 130'(out_valid), 130'd0);
        chk("post hs in_ready", 130'(in_ready), 130'd1);
        chk("post hs result held", result, 130'd16);

        for (int i = 4; i < 11; i++)
            txn(tbl[i].ch, tbl[i].clr, tbl[i].d, tbl[i].k,
                tbl[i].eu, tbl[i].es, 1'b0, $sformatf("vec%0d", i));

        // reset asserted in the middle of CALC
        @(negedge clk);
        in_chan = 2'd0;
        in_data = 64'd9;
        kernel = kd;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset out_valid", 130'(out_valid), 130'd0);
        chk("midreset in_ready", 130'(in_ready), 130'd1);
        chk("midreset result", result, 130'd0);
        chk("midreset signed out_valid", 130'(ov_s), 130'd0);
        mdl_reset();
        @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 64'd1, kd, 130'd1, 130'd1, 1'b0, "after reset");

        for (int i = 0; i < 16; i++) begin
            kr = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            txn(int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                {$urandom, $urandom}, kr, '0, '0, 1'b1,
                $sformatf("soak%0d", i));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", cnt, errs);
        $finish;
    end

endmodule
